dogx_output_framer: RTL and testbench

- Consumes the DOGX converter output stream: 11-bit words at 6 MHz in mode 0, or 1-bit samples at 3 MHz in mode 1, plus the 3 MHz output clock and alpha.
- Packs samples into 24-bit frames and buffers them in a small FIFO.
- Presents the frames on a valid/ready stream for the downstream serial or host interface.
- Sits directly downstream of the digital converter top and runs in the same CLK_24M domain.

---
 rtl/dogx_framer_pkg.sv | 25 ++
 rtl/dogx_output_framer_if.sv | 14 +
 rtl/dogx_sync_fifo.sv | 84 ++++++++
 rtl/dogx_output_framer.sv | 159 +++++++++++++++
 tb/tb_dogx_output_framer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/dogx_framer_pkg.sv
// dogx_framer_pkg: shared widths, frame bit positions and pair-state
// encoding for the DOGX output framer, plus the mode-0 frame builder.
package dogx_framer_pkg;

  localparam int FRAME_W   = 24;
  localparam int DATA_W    = 11;
  localparam int SHIFT_W   = FRAME_W - 1;
  localparam int ALPHA_BIT = 23;
  localparam int MODE_BIT  = 0;

  typedef enum logic [0:0] {
    WAIT_HSNR = 1'b0,
    WAIT_HDR  = 1'b1
  } pair_state_t;

  // Mode-0 frame: alpha in bit 23, HDR, HSNR, mode flag 0 in bit 0.
  function automatic logic [FRAME_W-1:0] pair_frame(
    input logic              alpha,
    input logic [DATA_W-1:0] hdr,
    input logic [DATA_W-1:0] hsnr
  );
    return {alpha, hdr, hsnr, 1'b0};
  endfunction

endpackage

// File: rtl/dogx_output_framer_if.sv
// dogx_output_framer_if: valid/ready frame stream.
//   m_data  : 24-bit frame
//   m_valid : frame available (master drives)
//   m_ready : downstream accepts (slave drives)
interface dogx_output_framer_if;
  import dogx_framer_pkg::*;

  logic [FRAME_W-1:0] m_data;
  logic               m_valid;
  logic               m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/dogx_sync_fifo.sv
// dogx_sync_fifo: synchronous FIFO with a registered head word.
//   clk, reset : clock, synchronous active-high reset
//   push/din   : write request and data (dropped when full unless popping)
//   pop        : remove head (ignored when empty)
//   dout       : registered head entry, valid while !empty
//   full/empty : registered occupancy flags
module dogx_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r, rd_ptr_n_s;
  logic [CW-1:0]    cnt_r, cnt_n_s;
  logic [WIDTH-1:0] dout_r;
  logic             full_r, empty_r;
  logic             do_push_s, do_pop_s;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop_s  = pop && !empty_r;
  assign do_push_s = push && (!full_r || do_pop_s);

  // Next read pointer and occupancy.
  always_comb begin
    rd_ptr_n_s = rd_ptr_r;
    cnt_n_s    = cnt_r + CW'(do_push_s) - CW'(do_pop_s);
    if (do_pop_s) begin
      rd_ptr_n_s = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_n_s = rd_ptr_r;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, flags and registered head word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      dout_r   <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_ptr_n_s;
      cnt_r    <= cnt_n_s;
      full_r   <= (cnt_n_s == CW'(DEPTH));
      empty_r  <= (cnt_n_s == CW'(0));
      // The new head is the word being written when it lands in the slot
      // the read pointer moves to (FIFO otherwise empty after this cycle).
      if (cnt_n_s != CW'(0)) begin
        if (do_push_s && (rd_ptr_n_s == wr_ptr_r)) begin
          dout_r <= din;
        end else begin
          dout_r <= mem_r[rd_ptr_n_s];
        end
      end
    end
  end

  assign dout  = dout_r;
  assign full  = full_r;
  assign empty = empty_r;
endmodule

// File: rtl/dogx_output_framer.sv
// dogx_output_framer: packs DOGX converter output into 24-bit frames.
//   CLK_24M, reset   : system clock, synchronous active-high reset
//   operation_mode   : 0 = paired 11-bit words, 1 = 1-bit bitstream
//   converter_output : converter data word
//   clock_3M_in      : converter output clock; its level tags HDR(1)/HSNR(0)
//   alpha_in         : channel select, stored in bit 23 of paired frames
//   m_if             : valid/ready frame stream (master side)
//   overflow         : sticky, frame dropped on full FIFO
//   sync_error       : sticky, HDR/HSNR ordering violated
//   clear_flags      : clears both sticky flags (set wins)
module dogx_output_framer
  import dogx_framer_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int SAMPLE_DELAY = 2
) (
  input  logic              CLK_24M,
  input  logic              reset,
  input  logic              operation_mode,
  input  logic [DATA_W-1:0] converter_output,
  input  logic              clock_3M_in,
  input  logic              alpha_in,
  dogx_output_framer_if.master m_if,
  output logic              overflow,
  output logic              sync_error,
  input  logic              clear_flags
);
  localparam logic [0:0] S_WAIT_HSNR = WAIT_HSNR;
  localparam logic [0:0] S_WAIT_HDR  = WAIT_HDR;

  logic                    clk3_q_r, mode_q_r;
  logic [SAMPLE_DELAY-1:0] stb_pipe_r, tag_pipe_r;
  logic                    edge_s, strobe_s, tag_s, mode_chg_s;
  logic [0:0]              state_r, state_n_s;
  logic [DATA_W-1:0]       hsnr_r, hsnr_n_s;
  logic [SHIFT_W-1:0]      shift_r, shift_n_s;
  logic [4:0]              cnt_r, cnt_n_s;
  logic                    push_s, pop_s, sync_set_s, ovf_set_s;
  logic [FRAME_W-1:0]      frame_s;
  logic                    fifo_full_s, fifo_empty_s;
  logic                    overflow_r, sync_error_r;

  assign edge_s     = (clock_3M_in != clk3_q_r);
  assign strobe_s   = stb_pipe_r[SAMPLE_DELAY-1];
  assign tag_s      = tag_pipe_r[SAMPLE_DELAY-1];
  assign mode_chg_s = (operation_mode != mode_q_r);

  // Pair FSM / bitstream packer next-state and frame push.
  always_comb begin
    state_n_s  = state_r;
    hsnr_n_s   = hsnr_r;
    shift_n_s  = shift_r;
    cnt_n_s    = cnt_r;
    push_s     = 1'b0;
    frame_s    = '0;
    sync_set_s = 1'b0;
    if (mode_chg_s) begin
      // Partial work is discarded; a strobe in this cycle is ignored.
      state_n_s = S_WAIT_HSNR;
      shift_n_s = '0;
      cnt_n_s   = 5'd0;
    end else if (strobe_s && !operation_mode) begin
      case (state_r)
        S_WAIT_HSNR: begin
          if (!tag_s) begin
            hsnr_n_s  = converter_output;
            state_n_s = S_WAIT_HDR;
          end else begin
            sync_set_s = 1'b1;
          end
        end
        S_WAIT_HDR: begin
          if (tag_s) begin
            push_s    = 1'b1;
            frame_s   = pair_frame(alpha_in, converter_output, hsnr_r);
            state_n_s = S_WAIT_HSNR;
          end else begin
            hsnr_n_s   = converter_output;
            sync_set_s = 1'b1;
          end
        end
        default: begin
          state_n_s = S_WAIT_HSNR;
        end
      endcase
    end else if (strobe_s && tag_s) begin
      // Bitstream: rising-edge samples only, MSB first.
      shift_n_s = {shift_r[SHIFT_W-2:0], converter_output[0]};
      if (cnt_r == 5'd22) begin
        push_s  = 1'b1;
        frame_s = {shift_r[SHIFT_W-2:0], converter_output[0], 1'b1};
        cnt_n_s = 5'd0;
      end else begin
        cnt_n_s = cnt_r + 5'd1;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  assign pop_s     = !fifo_empty_s && m_if.m_ready;
  assign ovf_set_s = push_s && fifo_full_s && !pop_s;

  // Edge pipeline, framing state and sticky flags.
  always_ff @(posedge CLK_24M) begin
    // Follow the inputs even in reset so release does not fake a change.
    clk3_q_r <= clock_3M_in;
    mode_q_r <= operation_mode;
    if (reset) begin
      stb_pipe_r   <= '0;
      tag_pipe_r   <= '0;
      state_r      <= S_WAIT_HSNR;
      hsnr_r       <= '0;
      shift_r      <= '0;
      cnt_r        <= 5'd0;
      overflow_r   <= 1'b0;
      sync_error_r <= 1'b0;
    end else begin
      stb_pipe_r[0] <= edge_s;
      tag_pipe_r[0] <= clock_3M_in;
      for (int i = 1; i < SAMPLE_DELAY; i++) begin
        stb_pipe_r[i] <= stb_pipe_r[i-1];
        tag_pipe_r[i] <= tag_pipe_r[i-1];
      end
      state_r <= state_n_s;
      hsnr_r  <= hsnr_n_s;
      shift_r <= shift_n_s;
      cnt_r   <= cnt_n_s;
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (clear_flags) begin
        overflow_r <= 1'b0;
      end
      if (sync_set_s) begin
        sync_error_r <= 1'b1;
      end else if (clear_flags) begin
        sync_error_r <= 1'b0;
      end
    end
  end

  dogx_sync_fifo #(
    .WIDTH(FRAME_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (CLK_24M),
    .reset(reset),
    .push (push_s),
    .pop  (pop_s),
    .din  (frame_s),
    .dout (m_if.m_data),
    .full (fifo_full_s),
    .empty(fifo_empty_s)
  );

  assign m_if.m_valid = !fifo_empty_s;
  assign overflow     = overflow_r;
  assign sync_error   = sync_error_r;
endmodule

// File: tb/tb_dogx_output_framer.sv
// tb_dogx_output_framer: directed stimulus with a frame scoreboard.
module tb_dogx_output_framer;
  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [10:0] conv;
  logic        clk3;
  logic        alpha;
  logic        clear_flags;
  logic        overflow;
  logic        sync_error;

  int checks   = 0;
  int failures = 0;
  logic [23:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [23:0] stall_data = 24'd0;

  dogx_output_framer_if s_if ();

  dogx_output_framer #(.FIFO_DEPTH(8), .SAMPLE_DELAY(2)) dut (
    .CLK_24M(clk), .reset(reset), .operation_mode(mode),
    .converter_output(conv), .clock_3M_in(clk3), .alpha_in(alpha),
    .m_if(s_if), .overflow(overflow), .sync_error(sync_error),
    .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", nm, got, req);
    end
  endtask

  function automatic logic [23:0] f0(input logic a, input logic [10:0] hd, input logic [10:0] hs);
    return {a, hd, hs, 1'b0};
  endfunction

  // Scoreboard monitor: compares every accepted frame and stall stability.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && s_if.m_valid)
        chk("stall_hold", s_if.m_data, stall_data);
      if (s_if.m_valid && s_if.m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame got=%h required=none", s_if.m_data);
        end else begin
          chk("frame_data", s_if.m_data, exp_q.pop_front());
        end
      end
      stall_prev = s_if.m_valid && !s_if.m_ready;
      stall_data = s_if.m_data;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One half period of clock_3M_in (4 system cycles) carrying a data word.
  task automatic half(input logic lvl, input logic [10:0] d);
    clk3 = lvl;
    conv = d;
    cyc(4);
  endtask

  task automatic send_pair(input logic a, input logic [10:0] hs, input logic [10:0] hd);
    alpha = a;
    half(1'b0, hs);
    half(1'b1, hd);
  endtask

  // Bits pat[22-first] downward; falling edges carry a decoy LSB of 1.
  task automatic send_bits(input logic [22:0] pat, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      half(1'b0, 11'h7FF);
      half(1'b1, {10'h155, pat[22-first-i]});
    end
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    cyc(1);
    clear_flags = 1'b0;
  endtask

  initial begin
    logic [22:0] pat_a;
    logic [22:0] pat_b;
    int c;
    pat_a = 23'b10110011100011110101101;
    pat_b = 23'h2AAAAA;
    reset = 1'b1; mode = 1'b0; conv = 11'd0; clk3 = 1'b1;
    alpha = 1'b0; clear_flags = 1'b0; s_if.m_ready = 1'b1;
    cyc(3);
    chk("rst_m_valid", 24'(s_if.m_valid), 24'd0);
    chk("rst_m_data", s_if.m_data, 24'd0);
    chk("rst_overflow", 24'(overflow), 24'd0);
    chk("rst_sync_error", 24'(sync_error), 24'd0);
    reset = 1'b0;
    cyc(2);

    // Paired mode, downstream always ready.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(24'hAAA2AA);
      send_pair(1'b1, 11'h155, 11'h2AA);
    end
    cyc(4);
    chk("t1_drained", 24'(exp_q.size()), 24'd0);

    // Bitstream mode: nothing before the 23rd sample.
    s_if.m_ready = 1'b0;
    mode = 1'b1;
    cyc(4);
    send_bits(pat_a, 0, 22);
    chk("t2_no_early_frame", 24'(s_if.m_valid), 24'd0);
    exp_q.push_back(24'hB38F5B);
    send_bits(pat_a, 22, 1);
    chk("t2_frame_valid", 24'(s_if.m_valid), 24'd1);
    s_if.m_ready = 1'b1;
    cyc(3);
    chk("t2_drained", 24'(exp_q.size()), 24'd0);

    // Mode change discards a partial bitstream and resets the counter.
    s_if.m_ready = 1'b0;
    send_bits(pat_a, 0, 10);
    mode = 1'b0;
    cyc(4);
    chk("t5_no_frame", 24'(s_if.m_valid), 24'd0);
    exp_q.push_back(24'h456246);
    send_pair(1'b0, 11'h123, 11'h456);
    s_if.m_ready = 1'b1;
    cyc(3);
    s_if.m_ready = 1'b0;
    mode = 1'b1;
    cyc(4);
    send_bits(pat_b, 0, 22);
    chk("t5_counter_cleared", 24'(s_if.m_valid), 24'd0);
    exp_q.push_back(24'h555555);
    send_bits(pat_b, 22, 1);
    s_if.m_ready = 1'b1;
    cyc(3);
    chk("t5_drained", 24'(exp_q.size()), 24'd0);
    mode = 1'b0;
    cyc(4);

    // Overflow: 10 frames into an 8-deep FIFO with no reader.
    s_if.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp_q.push_back(f0(i[0], 11'(i * 101 + 7), 11'(i * 37 + 5)));
      send_pair(i[0], 11'(i * 37 + 5), 11'(i * 101 + 7));
      if (i == 7) chk("t3_no_ovf_at_full", 24'(overflow), 24'd0);
    end
    chk("t3_overflow", 24'(overflow), 24'd1);
    chk("t3_valid", 24'(s_if.m_valid), 24'd1);
    c = 0;
    while (c < 300 && exp_q.size() != 0) begin
      s_if.m_ready = (c % 3 != 0);
      cyc(1);
      c++;
    end
    chk("t3_drain_done", 24'(exp_q.size()), 24'd0);
    s_if.m_ready = 1'b1;
    cyc(2);
    chk("t3_empty", 24'(s_if.m_valid), 24'd0);
    chk("t3_ovf_sticky", 24'(overflow), 24'd1);
    pulse_clear();
    chk("t3_ovf_cleared", 24'(overflow), 24'd0);

    // Reset with 3 queued frames, a sync error and a partial pair pending.
    s_if.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_pair(1'b1, 11'(i + 1), 11'(i + 9));
    half(1'b0, 11'h0F0);
    mode = 1'b1;
    cyc(2);
    mode = 1'b0;
    cyc(4);
    half(1'b1, 11'h0E0);
    chk("t6_sync_set", 24'(sync_error), 24'd1);
    half(1'b0, 11'h0D0);
    chk("t6_queued", 24'(s_if.m_valid), 24'd1);
    reset = 1'b1;
    cyc(1);
    chk("t6_rst_valid", 24'(s_if.m_valid), 24'd0);
    chk("t6_rst_overflow", 24'(overflow), 24'd0);
    chk("t6_rst_sync", 24'(sync_error), 24'd0);
    exp_q.delete();
    cyc(2);
    reset = 1'b0;
    s_if.m_ready = 1'b1;
    cyc(1);

    // Start on an HDR edge: discarded, flagged, then normal pairing.
    half(1'b1, 11'h7FF);
    chk("t4_sync_error", 24'(sync_error), 24'd1);
    chk("t4_no_frame", 24'(s_if.m_valid), 24'd0);
    exp_q.push_back(24'hBCD156);
    send_pair(1'b1, 11'h0AB, 11'h3CD);
    cyc(3);
    chk("t4_drained", 24'(exp_q.size()), 24'd0);
    pulse_clear();
    chk("t4_sync_cleared", 24'(sync_error), 24'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
